// File: rtl/rr_grant_sequencer_pkg.sv
// Shared definitions for the round-robin grant sequencer.
//   arb_state_t : sequencer FSM state encoding (IDLE, READY, BUSY)
//   idx_width() : width of a client index for a given client count
//   next_idx()  : successor of an index modulo a client count
package rr_grant_sequencer_pkg;

  // Largest supported client count and the index width that covers it.
  localparam int MAX_N   = 16;
  localparam int MAX_IDW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  // Owner index width; a single-client count still needs one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // (idx + 1) mod n, computed one bit wider than any legal index so the
  // increment of the top index cannot wrap before the compare with n.
  function automatic logic [MAX_IDW:0] next_idx(input logic [MAX_IDW:0] idx,
                                                input logic [MAX_IDW:0] n);
    logic [MAX_IDW:0] inc;
    inc = idx + (MAX_IDW+1)'(1);
    return (inc >= n) ? '0 : inc;
  endfunction

endpackage

// File: rtl/rr_grant_sequencer_pick.sv
// Combinational rotate-priority picker.
//   req     in  N    request vector, bit i belongs to client i
//   ptr     in  IDW  client that has highest priority this round
//   winner  out IDW  first requesting client searching ptr, ptr+1, ..., wrapping
//   any_req out 1    at least one request bit is set
module rr_pick
  import rr_grant_sequencer_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idx_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] winner,
  output logic           any_req
);

  logic [MAX_IDW:0] cand;
  logic             found;

  // Walk the candidates in round-robin order starting at ptr; the first
  // requesting candidate wins and later ones are ignored.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = (MAX_IDW+1)'(ptr);
    for (int k = 0; k < N; k++) begin
      if (!found && req[cand[IDW-1:0]]) begin
        winner = cand[IDW-1:0];
        found  = 1'b1;
      end
      cand = next_idx(cand, (MAX_IDW+1)'(N));
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_grant_sequencer.sv
// Central round-robin sequencer granting one shared resource to N clients
// over a four-phase req/ack handshake.
//   clk       in  1    rising-edge clock
//   rst       in  1    synchronous active-high reset
//   req       in  N    per-client request
//   ack       out N    per-client acknowledge, one-hot or zero
//   sel       out IDW  current owner index, meaningful while sel_valid is high
//   sel_valid out 1    high in READY and BUSY
//   busy      out 1    high in BUSY
//   overrun   out 1    sticky: the owner held the grant beyond MAX_HOLD cycles
// Every output comes straight from a flop; req only reaches next-state logic.
module rr_grant_sequencer
  import rr_grant_sequencer_pkg::*;
#(
  parameter int N        = 4,
  parameter int IDW      = idx_width(N),
  parameter int MAX_HOLD = 15,
  parameter int CW       = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   ack,
  output logic [IDW-1:0] sel,
  output logic           sel_valid,
  output logic           busy,
  output logic           overrun
);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] sel_q, sel_d;
  logic           sel_valid_q, sel_valid_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           busy_q, busy_d;
  logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           overrun_q, overrun_d;

  logic [IDW-1:0] pick_winner;
  logic           pick_any;
  logic [IDW:0]   sel_inc;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (pick_winner),
    .any_req (pick_any)
  );

  // One extra bit so sel = N-1 increments to N instead of wrapping to 0
  // before the modulo compare.
  assign sel_inc = {1'b0, sel_q} + (IDW+1)'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    ack_d       = ack_q;
    busy_d      = busy_q;
    hold_cnt_d  = hold_cnt_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d       = pick_winner;
          sel_valid_d = 1'b1;
          state_d     = READY;
        end
      end
      // Grant unconditionally: a request withdrawn during READY still sees
      // one ack cycle and is released from BUSY on the following edge.
      READY: begin
        ack_d      = N'(1) << sel_q;
        busy_d     = 1'b1;
        hold_cnt_d = '0;
        state_d    = BUSY;
      end
      BUSY: begin
        if (!req[sel_q]) begin
          ack_d       = '0;
          busy_d      = 1'b0;
          sel_valid_d = 1'b0;
          // The released owner becomes lowest priority for the next round.
          ptr_d       = (sel_inc == (IDW+1)'(N)) ? '0 : sel_inc[IDW-1:0];
          state_d     = IDLE;
        end else if (hold_cnt_q == CW'(MAX_HOLD)) begin
          // Advisory only; the owner keeps the grant.
          overrun_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      hold_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      hold_cnt_q  <= hold_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ack       = ack_q;
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer (N=4, MAX_HOLD=3).
module tb_rr_grant_sequencer;

  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 3;
  localparam int CW       = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   ack;
  logic [IDW-1:0] sel;
  logic           sel_valid;
  logic           busy;
  logic           overrun;

  int vectors     = 0;
  int miscompares = 0;

  rr_grant_sequencer #(
    .N        (N),
    .IDW      (IDW),
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Step until some ack bit rises (bounded), checking ack never has two bits set.
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (ack == '0 && n < 12) begin
      step(1);
      chk({tag, "_onehot"}, 32'($countones(ack) <= 1), 1);
      n++;
    end
    chk({tag, "_granted"}, 32'(ack != '0), 1);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    req = '0;
    step(2);
    chk("rst_ack", ack, 0);
    chk("rst_sel", sel, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ptr", dut.ptr_q, 0);
    chk("rst_hold", dut.hold_cnt_q, 0);
    rst = 1'b0;

    // 1: single client, latency and release
    req = 4'b0001;
    step(1);
    chk("t1_ready_valid", sel_valid, 1);
    chk("t1_ready_ack", ack, 0);
    step(1);
    chk("t1_ack", ack, 4'b0001);
    chk("t1_sel", sel, 0);
    chk("t1_busy", busy, 1);
    req = 4'b0000;
    step(1);
    chk("t1_rel_ack", ack, 0);
    chk("t1_rel_busy", busy, 0);
    chk("t1_rel_valid", sel_valid, 0);
    chk("t1_rel_ptr", dut.ptr_q, 1);

    // 2: all clients requesting, rotate 0,1,2,3,0
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t2");
      chk("t2_sel", sel, k % 4);
      chk("t2_ack", ack, 1 << (k % 4));
      req[k % 4] = 1'b0;
      step(1);
      chk("t2_rel", ack, 0);
      if (k < 4) req[k % 4] = 1'b1;
    end
    req = 4'b0000;

    // 3: wrap-around after owner 3
    req = 4'b1000;
    wait_grant("t3a");
    chk("t3_sel3", sel, 3);
    req = 4'b0000;
    step(1);
    chk("t3_ptr_wrap", dut.ptr_q, 0);
    req = 4'b1001;
    wait_grant("t3b");
    chk("t3_sel0", sel, 0);
    chk("t3_ack0", ack, 4'b0001);
    req[0] = 1'b0;
    step(1);
    chk("t3_rel0", ack, 0);
    req[0] = 1'b1;
    wait_grant("t3c");
    chk("t3_sel3b", sel, 3);
    chk("t3_ack3", ack, 4'b1000);
    req = 4'b0000;
    step(1);
    chk("t3_rel3", ack, 0);

    // 4: hold overrun with MAX_HOLD=3
    req = 4'b0100;
    wait_grant("t4");
    chk("t4_ack", ack, 4'b0100);
    step(2);
    chk("t4_no_overrun", overrun, 0);
    step(3);
    chk("t4_overrun", overrun, 1);
    chk("t4_ack_held", ack, 4'b0100);
    step(5);
    chk("t4_ack_held10", ack, 4'b0100);
    chk("t4_busy10", busy, 1);
    chk("t4_hold_sat", dut.hold_cnt_q, MAX_HOLD);
    req = 4'b0000;
    step(1);
    chk("t4_rel_ack", ack, 0);
    chk("t4_sticky", overrun, 1);
    step(3);
    chk("t4_sticky_later", overrun, 1);

    // 5: reset in BUSY, then fresh grant
    req = 4'b0100;
    wait_grant("t5");
    chk("t5_ack", ack, 4'b0100);
    rst = 1'b1;
    step(1);
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_sel", sel, 0);
    chk("t5_rst_valid", sel_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_overrun", overrun, 0);
    rst = 1'b0;
    step(1);
    chk("t5_ready_ack", ack, 0);
    chk("t5_ready_valid", sel_valid, 1);
    chk("t5_ready_sel", sel, 2);
    step(1);
    chk("t5_regrant", ack, 4'b0100);

    // 6: request withdrawn during READY
    req = 4'b0000;
    step(1);
    chk("t6_pre_ack", ack, 0);
    chk("t6_pre_ptr", dut.ptr_q, 3);
    req = 4'b0010;
    step(1);
    chk("t6_ready_sel", sel, 1);
    chk("t6_ready_ack", ack, 0);
    req = 4'b0000;
    step(1);
    chk("t6_pulse", ack, 4'b0010);
    chk("t6_busy", busy, 1);
    step(1);
    chk("t6_drop", ack, 0);
    chk("t6_valid", sel_valid, 0);
    chk("t6_ptr", dut.ptr_q, 2);
    step(2);
    chk("t6_quiet", ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
